// File: rtl/shift_sub_divider_pkg.sv
// Shared types and helpers for the shift-subtract divider.
// State codes are fixed so that host FSMs can decode them directly.
package shift_sub_divider_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_ITER = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    ITER = ST_ITER,
    DONE = ST_DONE
  } state_t;

  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1)
      r++;
    return r;
  endfunction

endpackage

// File: rtl/shift_sub_divider_if.sv
// Start/done bus between a host FSM and the divider.
// The host drives operands; the divider returns registered results.
interface shift_sub_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder,
    input  busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder,
    output busy, done, div_by_zero
  );
endinterface

// File: rtl/shift_sub_divider_counter.sv
// Iteration counter: loaded with WIDTH-1, counts down once per ITER cycle.
// cnt_zero marks the final quotient bit.
module shift_sub_divider_counter
  import shift_sub_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic cnt_zero
);
  localparam int CW = log2c(WIDTH) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= CW'(WIDTH - 1);
    else if (dec)
      cnt <= cnt - CW'(1);
  end

  assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/shift_sub_divider_datapath.sv
// Restoring-division datapath: P/Q/D registers, subtractor, result regs.
// Results are written on the edge entering DONE from next-step values.
module shift_sub_divider_datapath #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             step,
  input  logic             fin,
  input  logic             fin_zero,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  logic [WIDTH:0]   p, p_nx, s, t;
  logic [WIDTH-1:0] q, q_nx, d;

  assign div_zero = (divisor == '0);

  // s = {P[WIDTH-1:0], Q msb}; P msb is always zero between steps
  always_comb begin
    s = (p << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};
    t = s - {1'b0, d};
    if (!t[WIDTH]) begin
      p_nx = t;
      q_nx = {q[WIDTH-2:0], 1'b1};
    end else begin
      p_nx = s;
      q_nx = {q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p           <= '0;
      q           <= '0;
      d           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (ld) begin
        p <= '0;
        q <= dividend;
        d <= divisor;
      end else if (step) begin
        p <= p_nx;
        q <= q_nx;
      end
      if (fin) begin
        quotient    <= q_nx;
        remainder   <= p_nx[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end else if (fin_zero) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_sub_divider_fsm.sv
// Controller: IDLE -> LOAD -> ITER* -> DONE -> IDLE.
// A zero divisor skips ITER and goes straight to DONE.
module shift_sub_divider_fsm
  import shift_sub_divider_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic div_zero,
  input  logic cnt_zero,
  output logic ld,
  output logic step,
  output logic fin,
  output logic fin_zero,
  output logic busy,
  output logic done
);
  state_t state, state_nx;

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    step     = 1'b0;
    fin      = 1'b0;
    fin_zero = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = LOAD;
      end
      LOAD: begin
        ld   = 1'b1;
        busy = 1'b1;
        if (div_zero) begin
          fin_zero = 1'b1;
          state_nx = DONE;
        end else begin
          state_nx = ITER;
        end
      end
      ITER: begin
        step = 1'b1;
        busy = 1'b1;
        if (cnt_zero) begin
          fin      = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Top level only wires controller, counter and datapath to the bus.
module shift_sub_divider #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_sub_divider_if.slave    bus
);
  logic ld, step, fin, fin_zero;
  logic div_zero, cnt_zero;

  shift_sub_divider_fsm u_fsm (
    .clk      (clk),
    .rst      (rst),
    .start    (bus.start),
    .div_zero (div_zero),
    .cnt_zero (cnt_zero),
    .ld       (ld),
    .step     (step),
    .fin      (fin),
    .fin_zero (fin_zero),
    .busy     (bus.busy),
    .done     (bus.done)
  );

  shift_sub_divider_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .dec      (step),
    .cnt_zero (cnt_zero)
  );

  shift_sub_divider_datapath #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk         (clk),
    .rst         (rst),
    .ld          (ld),
    .step        (step),
    .fin         (fin),
    .fin_zero    (fin_zero),
    .dividend    (bus.dividend),
    .divisor     (bus.divisor),
    .div_zero    (div_zero),
    .quotient    (bus.quotient),
    .remainder   (bus.remainder),
    .div_by_zero (bus.div_by_zero)
  );

endmodule

// File: tb/tb_shift_sub_divider.sv
// Bench for shift_sub_divider: cycle model plus directed and random ops.
// Inputs change on negedge; outputs are compared on negedge.
module tb_shift_sub_divider;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  shift_sub_divider_if #(.WIDTH(W)) bus();

  shift_sub_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // {div_by_zero, quotient, remainder} from plain arithmetic
  function automatic logic [2*W:0] ref_div(input int a, input int b);
    logic [W-1:0] q, r;
    if (b == 0) begin
      q = '1;
      r = W'(a);
      return {1'b1, q, r};
    end
    q = W'(a / b);
    r = W'(a % b);
    return {1'b0, q, r};
  endfunction

  // m_t: cycles since acceptance (0 = idle); m_end: value of m_t in DONE
  int           m_t   = 0;
  int           m_end = 0;
  logic [2*W:0] m_pend = '0;
  logic [W-1:0] m_q   = '0;
  logic [W-1:0] m_r   = '0;
  logic         m_z   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_t   <= 0;
      m_end <= 0;
      m_q   <= '0;
      m_r   <= '0;
      m_z   <= 1'b0;
    end else if (m_t == 0) begin
      if (bus.start)
        m_t <= 1;
    end else if (m_t == 1) begin
      m_t    <= 2;
      m_end  <= (bus.divisor == 0) ? 2 : W + 2;
      m_pend <= ref_div(int'(bus.dividend), int'(bus.divisor));
      if (bus.divisor == 0)
        {m_z, m_q, m_r} <= ref_div(int'(bus.dividend), 0);
    end else if (m_t == m_end) begin
      m_t <= 0;
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == m_end)
        {m_z, m_q, m_r} <= m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", 32'(bus.busy), 32'(m_t != 0 && m_t != m_end));
      check("done", 32'(bus.done), 32'(m_t != 0 && m_t == m_end));
      check("quotient", 32'(bus.quotient), 32'(m_q));
      check("remainder", 32'(bus.remainder), 32'(m_r));
      check("div_by_zero", 32'(bus.div_by_zero), 32'(m_z));
    end
  end

  // Called at a negedge; counts negedges until done is seen.
  task automatic wait_done(input bit drop, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (drop && i == 1)
        bus.start = 1'b0;
      if (bus.busy)
        bcnt++;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0)
      check("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic op(input int a, input int b, output int lat,
                    output int bcnt);
    bus.dividend = W'(a);
    bus.divisor  = W'(b);
    bus.start    = 1'b1;
    wait_done(1'b1, lat, bcnt);
  endtask

  int lat, bcnt, pulses;
  logic [W-1:0] sq, sr;
  logic [2*W:0] exp_v;

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    check("rst_quotient", 32'(bus.quotient), 32'(0));
    check("rst_remainder", 32'(bus.remainder), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_dbz", 32'(bus.div_by_zero), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // 13/4
    op(13, 4, lat, bcnt);
    check("lat_13_4", 32'(lat), 32'(6));
    check("busy_cycles", 32'(bcnt), 32'(5));
    check("q_13_4", 32'(bus.quotient), 32'(3));
    check("r_13_4", 32'(bus.remainder), 32'(1));
    check("z_13_4", 32'(bus.div_by_zero), 32'(0));
    @(negedge clk);

    // 15/1 then 3/9 with start held high
    bus.dividend = 4'd15;
    bus.divisor  = 4'd1;
    bus.start    = 1'b1;
    wait_done(1'b0, lat, bcnt);
    check("q_15_1", 32'(bus.quotient), 32'(15));
    check("r_15_1", 32'(bus.remainder), 32'(0));
    bus.dividend = 4'd3;
    bus.divisor  = 4'd9;
    wait_done(1'b0, lat, bcnt);
    bus.start = 1'b0;
    check("b2b_gap", 32'(lat), 32'(7));
    check("q_3_9", 32'(bus.quotient), 32'(0));
    check("r_3_9", 32'(bus.remainder), 32'(3));
    @(negedge clk);

    // divide by zero, then a normal op clears the flag
    op(7, 0, lat, bcnt);
    check("lat_7_0", 32'(lat), 32'(2));
    check("q_7_0", 32'(bus.quotient), 32'(15));
    check("r_7_0", 32'(bus.remainder), 32'(7));
    check("z_7_0", 32'(bus.div_by_zero), 32'(1));
    @(negedge clk);
    op(9, 3, lat, bcnt);
    check("q_9_3", 32'(bus.quotient), 32'(3));
    check("r_9_3", 32'(bus.remainder), 32'(0));
    check("z_9_3", 32'(bus.div_by_zero), 32'(0));
    @(negedge clk);

    // start pulsed mid-ITER must be ignored
    bus.dividend = 4'd13;
    bus.divisor  = 4'd4;
    bus.start    = 1'b1;
    pulses = 0;
    sq = '0;
    sr = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 3) begin
        bus.start    = 1'b1;
        bus.dividend = 4'd7;
        bus.divisor  = 4'd2;
      end
      if (i == 4) bus.start = 1'b0;
      if (bus.done) begin
        pulses++;
        sq = bus.quotient;
        sr = bus.remainder;
      end
    end
    check("mid_pulses", 32'(pulses), 32'(1));
    check("mid_q", 32'(sq), 32'(3));
    check("mid_r", 32'(sr), 32'(1));

    // reset in the third ITER cycle of 14/3
    bus.dividend = 4'd14;
    bus.divisor  = 4'd3;
    bus.start    = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'(0));
    check("abort_done", 32'(bus.done), 32'(0));
    check("abort_q", 32'(bus.quotient), 32'(0));
    check("abort_r", 32'(bus.remainder), 32'(0));
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("abort_pulses", 32'(pulses), 32'(0));
    op(14, 3, lat, bcnt);
    check("q_14_3", 32'(bus.quotient), 32'(4));
    check("r_14_3", 32'(bus.remainder), 32'(2));
    @(negedge clk);

    // exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        op(a, b, lat, bcnt);
        exp_v = ref_div(a, b);
        check("sweep_res", 32'({bus.div_by_zero, bus.quotient, bus.remainder}),
              32'(exp_v));
        check("sweep_lat", 32'(lat), 32'((b == 0) ? 2 : 6));
        @(negedge clk);
      end
    end

    // random ops with random idle gaps
    for (int k = 0; k < 60; k++) begin
      op(int'($urandom_range(15)), int'($urandom_range(15)), lat, bcnt);
      repeat (1 + $urandom_range(3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
